// File: rtl/output_buffer_if.sv
// output_buffer_if: push side and row-output handshake of the output buffer.
// Ports: i_valid/i_data (per-column push), o_ready (row accept), o_valid/o_data (row out).
interface output_buffer_if #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 16
);
    logic [SYS_COLS-1:0]                 i_valid;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] i_data;
    logic                                o_ready;
    logic                                o_valid;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] o_data;

    modport master (
        output i_valid,
        output i_data,
        output o_ready,
        input  o_valid,
        input  o_data
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  o_ready,
        output o_valid,
        output o_data
    );
endinterface

// File: rtl/output_buffer.sv
// output_buffer: per-column FIFOs that deskew systolic-array results into rows.
// Ports: clk, rst (sync, high), clr (flush), bus (slave: push/row handshake),
//        o_count (complete rows), full (any column full), overflow (sticky drop).
package Config;
    localparam int sys_cols   = 4;
    localparam int P_BITWIDTH = 16;
endpackage

module output_buffer #(
    parameter int SYS_COLS   = Config::sys_cols,
    parameter int P_BITWIDTH = Config::P_BITWIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     full,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [P_BITWIDTH-1:0] r_mem    [SYS_COLS][DEPTH];
    logic [AW-1:0]         r_wr_ptr [SYS_COLS];
    logic [AW-1:0]         r_rd_ptr [SYS_COLS];
    logic [CW-1:0]         r_cnt    [SYS_COLS];
    logic                  r_overflow;

    logic [SYS_COLS-1:0]   w_full;
    logic [SYS_COLS-1:0]   w_nonempty;
    logic [SYS_COLS-1:0]   w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [CW-1:0]         w_min;

    // A full column may still accept a push when the row pops on the same edge.
    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        w_drop     = 1'b0;
        w_min      = r_cnt[0];
        for (int j = 0; j < SYS_COLS; j++) begin
            w_full[j]     = (r_cnt[j] == CW'(DEPTH));
            w_nonempty[j] = (r_cnt[j] != '0);
            if (r_cnt[j] < w_min) w_min = r_cnt[j];
        end
        w_pop = (&w_nonempty) & bus.o_ready;
        for (int j = 0; j < SYS_COLS; j++) begin
            w_push[j] = bus.i_valid[j] & (~w_full[j] | w_pop);
            if (bus.i_valid[j] & w_full[j] & ~w_pop) w_drop = 1'b1;
        end
    end

    always_comb begin
        bus.o_data = '0;
        for (int j = 0; j < SYS_COLS; j++) begin
            bus.o_data[j] = r_mem[j][r_rd_ptr[j]];
        end
    end

    assign bus.o_valid = &w_nonempty;
    assign o_count     = w_min;
    assign full        = |w_full;
    assign overflow    = r_overflow;

    // Storage is never reset; only pointers and counters define validity.
    always_ff @(posedge clk) begin
        for (int j = 0; j < SYS_COLS; j++) begin
            if (w_push[j] && !rst && !clr) begin
                r_mem[j][r_wr_ptr[j]] <= bus.i_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int j = 0; j < SYS_COLS; j++) begin
                r_wr_ptr[j] <= '0;
                r_rd_ptr[j] <= '0;
                r_cnt[j]    <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int j = 0; j < SYS_COLS; j++) begin
                if (w_push[j]) r_wr_ptr[j] <= r_wr_ptr[j] + 1'b1;
                if (w_pop)     r_rd_ptr[j] <= r_rd_ptr[j] + 1'b1;
                r_cnt[j] <= r_cnt[j] + CW'(w_push[j]) - CW'(w_pop);
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: directed checks of the deskewing output buffer.
// Ports: none (instantiates output_buffer with SYS_COLS=4, P_BITWIDTH=16, DEPTH=8).
module tb_output_buffer;
    logic       clk;
    logic       rst;
    logic       clr;
    logic [3:0] o_count;
    logic       full;
    logic       overflow;
    int         n_checks;
    int         n_errors;

    output_buffer_if #(.SYS_COLS(4), .P_BITWIDTH(16)) bus ();

    output_buffer #(
        .SYS_COLS(4),
        .P_BITWIDTH(16),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus),
        .o_count(o_count),
        .full(full),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] row(input int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(32 + r * 16 + j);
        return v;
    endfunction

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        clr         = 1'b0;
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // skewed row 10..13
        bus.i_valid = 4'b0001;
        bus.i_data  = 64'h0000_0000_0000_000A;
        step();
        chk("skew_partial", 64'(bus.o_valid), 64'd0);
        bus.i_valid = 4'b0010;
        bus.i_data  = 64'h0000_0000_000B_0000;
        step();
        bus.i_valid = 4'b0100;
        bus.i_data  = 64'h0000_000C_0000_0000;
        step();
        chk("skew_partial3", 64'(bus.o_valid), 64'd0);
        bus.i_valid = 4'b1000;
        bus.i_data  = 64'h000D_0000_0000_0000;
        step();
        bus.i_valid = '0;
        chk("skew_valid", 64'(bus.o_valid), 64'd1);
        chk("skew_data", bus.o_data, 64'h000D_000C_000B_000A);
        chk("skew_count", 64'(o_count), 64'd1);
        bus.o_ready = 1'b1;
        step();
        bus.o_ready = 1'b0;
        chk("skew_popped", 64'(bus.o_valid), 64'd0);

        // backpressure with 3 rows
        bus.i_valid = 4'hF;
        for (int r = 0; r < 3; r++) begin
            bus.i_data = row(r);
            step();
        end
        bus.i_valid = '0;
        chk("bp_count", 64'(o_count), 64'd3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_stall", bus.o_data, row(0));
        end
        bus.o_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            chk("bp_order", bus.o_data, row(r));
            step();
        end
        chk("bp_empty", 64'(bus.o_valid), 64'd0);
        step();
        chk("ready_no_valid", 64'(o_count), 64'd0);
        bus.o_ready = 1'b0;

        // full and overflow
        bus.i_valid = 4'hF;
        for (int r = 0; r < 8; r++) begin
            bus.i_data = row(r);
            step();
        end
        chk("full8", 64'(full), 64'd1);
        chk("count8", 64'(o_count), 64'd8);
        chk("no_ovf8", 64'(overflow), 64'd0);
        bus.i_data = row(8);
        step();
        bus.i_valid = '0;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(o_count), 64'd8);
        bus.o_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            chk("ovf_drain", bus.o_data, row(r));
            step();
        end
        bus.o_ready = 1'b0;
        chk("ovf_empty", 64'(bus.o_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // flush with 4 rows and overflow set
        bus.i_valid = 4'hF;
        for (int r = 0; r < 4; r++) begin
            bus.i_data = row(r);
            step();
        end
        chk("flush_pre", 64'(o_count), 64'd4);
        clr        = 1'b1;
        bus.i_data = row(9);
        step();
        clr         = 1'b0;
        bus.i_valid = '0;
        chk("flush_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_ovf", 64'(overflow), 64'd0);
        step();
        chk("flush_nopush", 64'(o_count), 64'd0);

        // push+pop at full
        bus.i_valid = 4'hF;
        for (int r = 0; r < 8; r++) begin
            bus.i_data = row(r);
            step();
        end
        bus.i_data  = row(8);
        bus.o_ready = 1'b1;
        chk("pp_head", bus.o_data, row(0));
        step();
        bus.i_valid = '0;
        bus.o_ready = 1'b0;
        chk("pp_count", 64'(o_count), 64'd8);
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_full", 64'(full), 64'd1);
        bus.o_ready = 1'b1;
        for (int r = 1; r < 9; r++) begin
            chk("pp_drain", bus.o_data, row(r));
            step();
        end
        bus.o_ready = 1'b0;
        chk("pp_empty", 64'(bus.o_valid), 64'd0);

        // reset mid-row
        bus.i_valid = 4'b0011;
        bus.i_data  = 64'h0000_0000_0002_0001;
        step();
        bus.i_valid = '0;
        rst         = 1'b1;
        step();
        rst         = 1'b0;
        bus.i_valid = 4'hF;
        bus.i_data  = 64'h0008_0007_0006_0005;
        step();
        bus.i_valid = '0;
        chk("rstmid_valid", 64'(bus.o_valid), 64'd1);
        chk("rstmid_data", bus.o_data, 64'h0008_0007_0006_0005);
        chk("rstmid_count", 64'(o_count), 64'd1);

        // push+pop at occupancy 1, no fall-through
        bus.i_valid = 4'hF;
        bus.i_data  = row(3);
        bus.o_ready = 1'b1;
        chk("occ1_head", bus.o_data, 64'h0008_0007_0006_0005);
        step();
        bus.i_valid = '0;
        bus.o_ready = 1'b0;
        chk("occ1_count", 64'(o_count), 64'd1);
        chk("occ1_data", bus.o_data, row(3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter SYS_COLS, default Config::sys_cols, meaning the number of systolic array columns drained.
REQ-002 SHALL have parameter P_BITWIDTH, default Config::P_BITWIDTH, meaning the partial-sum width per column.
REQ-003 SHALL have parameter DEPTH, default 8, meaning the result rows buffered per column; must be a power of two and at least 2.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clr  input  1  synchronous flush of buffered data and flags.
REQ-007 i_valid  input  [SYS_COLS-1:0]  per-column push strobe from the array's of_data side.
REQ-008 i_data  input  [SYS_COLS-1:0][P_BITWIDTH-1:0]  per-column result element.
REQ-009 o_ready  input  1  downstream accepts a row.
REQ-010 o_valid  output  1  a complete, deskewed result row is presented.
REQ-011 o_data  output  [SYS_COLS-1:0][P_BITWIDTH-1:0]  the head row, with column j taken from column FIFO j.
REQ-012 o_count  output  [$clog2(DEPTH):0]  complete rows available, equal to the occupancy of the lowest-occupancy column.
REQ-013 full  output  1  high when any column FIFO holds DEPTH entries.
REQ-014 overflow  output  1  sticky flag; a push was dropped.

Function
REQ-015 SHALL implement one independent FIFO per column, each with its own wr_ptr, rd_ptr and occupancy counter of $clog2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH.
REQ-016 SHALL deskew results: the array delivers column j of a given row j cycles after column 0, and each column FIFO absorbs that skew independently.
REQ-017 SHALL push i_data[j] into FIFO j in a cycle where i_valid[j]=1 and FIFO j is not full, or is full and pops in the same cycle.
REQ-018 SHALL drop a push to a full, non-popping column, leave that FIFO unchanged, and set overflow on the next edge.
- overflow holds until rst or clr.
REQ-019 SHALL drive o_valid=1 exactly when every column FIFO is non-empty.
- o_valid and o_data are combinational from registered state.
- A row whose last column is written at edge t is visible in the cycle after edge t.
REQ-020 SHALL pop all column FIFOs together on an edge where o_valid && o_ready.
- No column pops on its own.
REQ-021 SHALL keep o_data stable while o_valid=1 and o_ready=0.
REQ-022 SHALL handle a simultaneous push and pop on a column with occupancy unchanged, both pointers advancing.
- This holds also at occupancy DEPTH (no overflow) and at occupancy 1 with o_valid=1.
REQ-023 SHALL not push into an empty FIFO and read the same element in the same cycle; a write is readable only from the next cycle (no fall-through).
REQ-024 SHALL give o_ready=1 with o_valid=0 no effect.
REQ-025 SHALL make full combinational: OR over columns of (occupancy==DEPTH).
REQ-026 SHALL make o_count combinational: minimum over columns of occupancy.
REQ-027 SHALL not reset the storage array contents; only pointers, counters and flags are reset.

Reset
REQ-028 SHALL, on rst=1 at an edge, zero all pointers and occupancies and clear overflow, overriding clr, push and pop.
- Outputs then read o_valid=0, o_count=0, full=0, overflow=0.
REQ-029 SHALL give clr=1 the same effect as rst on pointers, occupancies and overflow, and ignore push and pop in that cycle.
REQ-030 SHALL, on rst or clr mid-row (some columns pushed, others not), discard the partial row; no stale column data pairs with later rows.

Verification
REQ-031 Skewed row: SYS_COLS=4; push values 10,11,12,13 on columns 0..3 at cycles 0..3, o_ready=0 -> o_valid rises in cycle 4 with o_data={13,12,11,10}, o_count=1.
REQ-032 Backpressure: 3 rows buffered, o_ready=0 for 5 cycles then 1 -> o_data constant while stalled; rows emerge in push order on 3 consecutive edges; o_valid=0 afterwards.
REQ-033 Full/overflow: DEPTH=8; push 9 rows with o_ready=0 -> full=1 after the 8th row; the 9th push is dropped, overflow=1, o_count=8; draining returns rows 0..7 only.
REQ-034 Push+pop at full: occupancy 8 on all columns; all-column push with o_ready=1 in the same cycle -> o_count stays 8, overflow stays 0, the new row appears as the 8th entry.
REQ-035 Reset mid-row: columns 0..1 pushed, rst pulsed, then a full row {5,6,7,8} pushed -> the first o_data is {8,7,6,5}, with no residue from before reset.
REQ-036 Flush: clr=1 with 4 rows buffered and overflow=1 -> the next cycle shows o_valid=0, o_count=0, overflow=0; the push in the clr cycle is ignored.
